// File: rtl/sync_debounce_pkg.sv
// Shared constants and types for the keypad line synchroniser/debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package sync_debounce_pkg;

  // Default timing: 10 ms debounce window on a 27 MHz system clock.
  localparam int CLK_HZ                  = 27_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Keypad geometry; the channel vector is {columns, rows}.
  localparam int KEYPAD_ROWS = 4;
  localparam int KEYPAD_COLS = 4;
  localparam int KEYPAD_CH   = KEYPAD_ROWS + KEYPAD_COLS;

  typedef logic [KEYPAD_CH-1:0] ch_vec_t;

endpackage

// File: rtl/module_sync_debounce_ch.sv
// Single-channel debouncer: mismatch counter, stable level, rise/fall pulse registers.
// Latency: DEBOUNCE_CYCLES consecutive mismatching cycles, then stable level and pulse update together.
// Backpressure: none; free-running every cycle.
`timescale 1ns/1ps
module module_debounce_ch
  import sync_debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sync,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall,
  output logic o_evt_nxt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_rise;
  logic             r_fall;
  logic             w_diff;
  logic             w_last;

  assign w_diff    = (i_sync != r_stable);
  assign w_last    = (r_cnt == CNT_LAST);
  // The stable level flips at the next edge; lets the top register an aggregate flag in step.
  assign o_evt_nxt = w_diff & w_last;

  // Count consecutive mismatches; any matching cycle restarts, the final mismatch commits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_stable <= RESET_LEVEL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_last) begin
        r_stable <= i_sync;
        r_cnt    <= '0;
        r_rise   <= i_sync;
        r_fall   <= ~i_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/module_sync_debounce.sv
// N_CH-line synchroniser + per-line debouncer with edge pulses and an aggregate change flag.
// Latency: SYNC_STAGES edges to o_sync_out, SYNC_STAGES + DEBOUNCE_CYCLES edges to a pulse.
// Backpressure: none; pulses are single-cycle and must be consumed when presented.
`timescale 1ns/1ps
module module_sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int   N_CH            = KEYPAD_CH,
  parameter int   SYNC_STAGES     = 2,  // legal 2..4
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,  // legal >= 1
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_async_in,
  output logic [N_CH-1:0] o_sync_out,
  output logic [N_CH-1:0] o_stable_out,
  output logic [N_CH-1:0] o_rise_pulse,
  output logic [N_CH-1:0] o_fall_pulse,
  output logic            o_any_change
);

  logic [N_CH-1:0] r_sync [SYNC_STAGES];
  logic [N_CH-1:0] w_evt_nxt;
  logic            r_any;

  // Plain shift chain per line; stage 0 is the metastability-catching flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= {N_CH{RESET_LEVEL}};
      end
    end else begin
      r_sync[0] <= i_async_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign o_sync_out = r_sync[SYNC_STAGES-1];

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      module_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (RESET_LEVEL)
      ) u_ch (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_sync   (o_sync_out[g]),
        .o_stable (o_stable_out[g]),
        .o_rise   (o_rise_pulse[g]),
        .o_fall   (o_fall_pulse[g]),
        .o_evt_nxt(w_evt_nxt[g])
      );
    end
  endgenerate

  // Aggregate flag registered from the same next-cycle events, so it lines up with the pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_evt_nxt;
    end
  end

  assign o_any_change = r_any;

endmodule
